// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one WIDTH-bit adder among N_REQ requesters.
// Optional macro ADDER_ARB_STATS_EN adds a saturating accepted-response counter (op_count).
module adder_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_cin,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_cout,
    output logic                   busy
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]            op_count
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [ID_W-1:0]  op_id_q, op_id_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;

    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];
    logic             grant_any;
    logic [ID_W-1:0]  grant_idx;
    logic [WIDTH:0]   sum_full;
    int               idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from farthest to nearest so the requester closest after last_grant wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(last_grant_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req_valid[ID_W'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE && grant_any) req_ready[grant_idx] = 1'b1;
    end

    assign sum_full = {1'b0, op_a_q} + {1'b0, op_b_q} + {{WIDTH{1'b0}}, op_cin_q};

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_id_d      = op_id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_cin_d     = op_cin_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    op_a_d       = a_arr[grant_idx];
                    op_b_d       = b_arr[grant_idx];
                    op_cin_d     = req_cin[grant_idx];
                    op_id_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                {rsp_cout_d, rsp_sum_d} = sum_full;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(N_REQ - 1);
            op_id_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_cin_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_id_q      <= op_id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_cin_q     <= op_cin_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = (state_q != IDLE);

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (rsp_valid_q && rsp_ready && op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) op_count_q <= 16'd0;
        else        op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (N_REQ=4, WIDTH=4).
// Stats checks are compiled in when ADDER_ARB_STATS_EN is defined.
module tb_adder_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_cin;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_sum;
    logic        rsp_cout;
    logic        busy;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0] op_count;
`endif

    int checks = 0;
    int errors = 0;

    adder_share_arbiter #(.N_REQ(4), .WIDTH(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
`ifdef ADDER_ARB_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        tick();
        rst_n = 1'b1;
    endtask

    // Issue one request from requester id, starting with the DUT idle, and check the full path.
    task automatic do_single(input int id, input logic [3:0] a, input logic [3:0] b,
                             input logic cin, input logic [3:0] exp_sum, input logic exp_cout);
        logic [3:0] exp_ready;
        exp_ready = 4'b0001 << id;
        req_a = '0; req_b = '0; req_cin = '0;
        req_a[id*4 +: 4] = a;
        req_b[id*4 +: 4] = b;
        req_cin[id]      = cin;
        req_valid        = exp_ready;
        rsp_ready        = 1'b1;
        #1;
        check("single_grant", req_ready, exp_ready);
        tick();
        req_valid = 4'b0000;
        check("exec_busy", busy, 1);
        check("exec_no_rsp", rsp_valid, 0);
        check("exec_no_ready", req_ready, 0);
        tick();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, id);
        check("rsp_sum", rsp_sum, exp_sum);
        check("rsp_cout", rsp_cout, exp_cout);
        $display("txn id=%0d a=%0h b=%0h cin=%0d -> sum=%0h cout=%0d", id, a, b, cin, rsp_sum, rsp_cout);
        tick();
        check("drain_idle", busy, 0);
        check("drain_rsp_clear", rsp_valid, 0);
    endtask

    int grant_id  [8];
    int grant_cyc [8];
    int ngrant;

    initial begin
        rst_n = 1'b0; req_valid = 4'b1111; req_a = 16'h1234; req_b = 16'h5678;
        req_cin = 4'b0000; rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_rsp_cout", rsp_cout, 0);
        check("rst_busy", busy, 0);
        do_reset();

        // Single request and carry corners
        do_single(2, 4'h7, 4'h9, 1'b0, 4'h0, 1'b1);
        do_single(0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
        do_single(1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        do_single(3, 4'h5, 4'h6, 1'b1, 4'hC, 1'b0);

        // Round-robin with all requesters active
        do_reset();
        req_a = 16'h4321; req_b = 16'h1111; req_cin = 4'b0101;
        req_valid = 4'b1111;
        ngrant = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (req_ready != 4'b0000) begin
                check("rr_onehot", $countones(req_ready), 1);
                if (ngrant < 8) begin
                    grant_cyc[ngrant] = c;
                    grant_id[ngrant]  = 0;
                    for (int i = 0; i < 4; i++) if (req_ready[i]) grant_id[ngrant] = i;
                end
                ngrant++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 4'b0000;
        check("rr_ngrant", ngrant, 5);
        for (int g = 0; g < 5; g++) begin
            check("rr_order", grant_id[g], g % 4);
            check("rr_cycle", grant_cyc[g], 3 * g);
            $display("txn rr grant=%0d cycle=%0d", grant_id[g], grant_cyc[g]);
        end

        // Back-pressure hold, then release
        do_reset();
        rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_cin = '0;
        req_a[7:4] = 4'h3; req_b[7:4] = 4'h4; req_cin[1] = 1'b1;
        req_valid = 4'b0010;
        #1;
        check("bp_grant", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1111;
        check("bp_exec_no_ready", req_ready, 0);
        tick();
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 1);
            check("bp_sum", rsp_sum, 4'h8);
            check("bp_cout", rsp_cout, 0);
            check("bp_ready", req_ready, 0);
            tick();
        end
        $display("txn bp id=%0d sum=%0h cout=%0d held", rsp_id, rsp_sum, rsp_cout);
        rsp_ready = 1'b1;
        #1;
        check("bp_nogrant_accept", req_ready, 0);
        tick();
        check("bp_idle", busy, 0);
        check("bp_rsp_clear", rsp_valid, 0);
        check("bp_next_grant", req_ready, 4'b0100);
        req_valid = 4'b0000;
        #1;

        // Reset while in EXEC discards the operation and restores priority to 0
        do_reset();
        req_valid = 4'b0001;
        #1;
        check("rx_grant0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        check("rx_in_exec", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rx_busy", busy, 0);
        for (int c = 0; c < 3; c++) begin
            check("rx_no_rsp", rsp_valid, 0);
            tick();
        end
        req_valid = 4'b0011;
        #1;
        check("rx_prio0", req_ready, 4'b0001);
        $display("txn rx after-reset grant=%b", req_ready);
        req_valid = 4'b0000;
        #1;

`ifdef ADDER_ARB_STATS_EN
        do_reset();
        check("cnt_rst", op_count, 0);
        for (int n = 0; n < 5; n++) do_single(n % 4, 4'h1, 4'h2, 1'b0, 4'h3, 1'b0);
        check("cnt_five", op_count, 5);
        do_reset();
        check("cnt_clear", op_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
